// File: rtl/key_event_decoder.sv
// Per-key gesture classifier: turns debounced press pulses and key levels into
// one-cycle single-click, double-click and long-press events.
module key_event_decoder #(
  parameter int unsigned N          = 1,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned LONG_TICKS = 6_000_000,
  parameter int unsigned DBL_TICKS  = 3_600_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] press_pulse,
  input  logic [N-1:0] key_n,
  output logic [N-1:0] single_click,
  output logic [N-1:0] double_click,
  output logic [N-1:0] long_press,
  output logic [N-1:0] key_busy
);

  typedef enum logic [2:0] {
    IDLE,
    HELD,
    GAP,
    LONG,
    WAIT_REL
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);

  for (genvar g = 0; g < int'(N); g++) begin : g_key
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             single_d, double_d, long_d;
    logic             single_q, double_q, long_q, busy_q;

    // Next-state, timer and event decode; release is checked before the
    // long-press deadline and a second press before the double-click deadline.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      single_d = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (press_pulse[g]) state_d = HELD;
        end
        HELD: begin
          if (key_n[g]) begin
            state_d = GAP;
            cnt_d   = '0;
          end else if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = LONG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (press_pulse[g]) begin
            double_d = 1'b1;
            state_d  = WAIT_REL;
            cnt_d    = '0;
          end else if (cnt_q == DBL_LAST) begin
            single_d = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LONG, WAIT_REL: begin
          cnt_d = '0;
          if (key_n[g]) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        single_q <= 1'b0;
        double_q <= 1'b0;
        long_q   <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        single_q <= single_d;
        double_q <= double_d;
        long_q   <= long_d;
        busy_q   <= (state_d != IDLE);
      end
    end

    assign single_click[g] = single_q;
    assign double_click[g] = double_q;
    assign long_press[g]   = long_q;
    assign key_busy[g]     = busy_q;
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed gestures plus random key
// activity on two keys, checked every cycle against a timestamp-based model.
module tb_key_event_decoder;
  localparam int unsigned N          = 2;
  localparam int unsigned CNT_W      = 24;
  localparam int unsigned LONG_TICKS = 20;
  localparam int unsigned DBL_TICKS  = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] press_pulse = '0;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] single_click, double_click, long_press, key_busy;

  key_event_decoder #(
    .N(N), .CNT_W(CNT_W), .LONG_TICKS(LONG_TICKS), .DBL_TICKS(DBL_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .press_pulse(press_pulse), .key_n(key_n),
    .single_click(single_click), .double_click(double_click),
    .long_press(long_press), .key_busy(key_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: per key a gesture phase plus the cycle number at which the phase
  // began; deadlines are elapsed-time differences against a global cycle count.
  typedef enum int {P_IDLE, P_DOWN, P_UP, P_SETTLE} phase_t;
  phase_t  ph [N];
  longint  t0 [N];
  longint  now = 0;
  logic [N-1:0] m_single = '0, m_double = '0, m_long = '0, m_busy = '0;
  int      left [N];

  task automatic model_step();
    for (int k = 0; k < int'(N); k++) begin
      m_single[k] = 1'b0;
      m_double[k] = 1'b0;
      m_long[k]   = 1'b0;
      if (rst) begin
        ph[k] = P_IDLE;
      end else begin
        case (ph[k])
          P_IDLE: if (press_pulse[k]) begin ph[k] = P_DOWN; t0[k] = now + 1; end
          P_DOWN: begin
            if (key_n[k]) begin ph[k] = P_UP; t0[k] = now + 1; end
            else if (now - t0[k] == longint'(LONG_TICKS) - 1) begin
              m_long[k] = 1'b1; ph[k] = P_SETTLE;
            end
          end
          P_UP: begin
            if (press_pulse[k]) begin m_double[k] = 1'b1; ph[k] = P_SETTLE; end
            else if (now - t0[k] == longint'(DBL_TICKS) - 1) begin
              m_single[k] = 1'b1; ph[k] = P_IDLE;
            end
          end
          default: if (key_n[k]) ph[k] = P_IDLE;
        endcase
      end
      m_busy[k] = (ph[k] != P_IDLE);
    end
    now++;
  endtask

  task automatic compare();
    for (int k = 0; k < int'(N); k++)
      check($sformatf("key%0d{busy,long,dbl,single}", k),
            32'({key_busy[k], long_press[k], double_click[k], single_click[k]}),
            32'({m_busy[k], m_long[k], m_double[k], m_single[k]}));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic gesture0(input int low, input int high);
    for (int i = 0; i < low; i++) begin
      key_n[0] = 1'b0; press_pulse[0] = (i == 0); cycle();
    end
    for (int i = 0; i < high; i++) begin
      key_n[0] = 1'b1; press_pulse[0] = 1'b0; cycle();
    end
  endtask

  function automatic int pick();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(1, 4));
      1:       return int'($urandom_range(18, 22));
      2:       return int'($urandom_range(8, 12));
      default: return int'($urandom_range(1, 40));
    endcase
  endfunction

  task automatic drive_rand();
    for (int k = 0; k < int'(N); k++) begin
      press_pulse[k] = 1'b0;
      if (left[k] <= 0) begin
        key_n[k] = ~key_n[k];
        if (!key_n[k]) press_pulse[k] = 1'b1;
        left[k] = pick();
      end
      left[k]--;
    end
  endtask

  initial begin
    for (int k = 0; k < int'(N); k++) begin ph[k] = P_IDLE; t0[k] = 0; left[k] = 0; end

    // Reset state
    repeat (3) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Gesture abandoned by an asynchronous mid-cycle reset
    for (int i = 0; i < 5; i++) begin key_n[0] = 1'b0; press_pulse[0] = (i == 0); cycle(); end
    check("busy_before_rst", 32'(key_busy[0]), 32'd1);
    #2 rst = 1'b1;
    #1 check("async_rst_outputs", 32'({single_click, double_click, long_press, key_busy}), 32'd0);
    press_pulse[0] = 1'b0;
    repeat (2) cycle();
    key_n[0] = 1'b1;
    rst = 1'b0;
    repeat (40) cycle();

    gesture0(5, 15);                    // single click
    gesture0(5, 4); gesture0(31, 15);   // double click, long hold after it
    gesture0(40, 10);                   // long press, no repeat
    gesture0(20, 15);                   // release at the long deadline
    gesture0(21, 5);                    // one cycle longer: long press
    gesture0(5, 10); gesture0(3, 15);   // second press at the gap deadline
    gesture0(5, 11); gesture0(3, 15);   // one cycle late: single, then new gesture
    gesture0(1, 15);                    // one-cycle press glitch

    // Key0 long press overlapping a key1 double click
    for (int i = 0; i < 60; i++) begin
      key_n[0] = !(i < 40);
      press_pulse[0] = (i == 0);
      key_n[1] = !((i >= 2 && i < 7) || (i >= 11 && i < 16));
      press_pulse[1] = (i == 2) || (i == 11);
      cycle();
    end

    // Random activity on both keys
    key_n = '1; press_pulse = '0;
    for (int i = 0; i < 4000; i++) begin drive_rand(); cycle(); end
    key_n = '1; press_pulse = '0;
    repeat (30) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
